nand_gate: RTL and testbench

//   Bitwise 2-input NAND primitive for the gate-level CPU build; the base cell other gates derive from.
//   Y is a purely combinational NAND of A and B, so Y stays correct with clk/rst tied off.

---
 rtl/nand_gate.sv | 60 ++++++
 tb/tb_nand_gate.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/nand_gate.sv
// nand_gate: bitwise 2-input NAND. This is the base cell for the gate-level CPU build.
// Y is purely combinational, so it stays valid even with clk and rst tied off.
// A registered copy of Y and a saturating transition counter are provided for timing and debug.
//
// Parameters:
//   WIDTH    bit width of A, B, Y and Y_q. Each bit is an independent NAND.
//   CNT_W    width of the transition counter
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous, active-high reset
//   A        in   WIDTH  operand A
//   B        in   WIDTH  operand B
//   Y        out  WIDTH  combinational ~(A & B)
//   Y_q      out  WIDTH  Y registered on clk
//   toggles  out  CNT_W  saturating count of edges at which Y_q changed value
module nand_gate #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic [CNT_W-1:0] toggles
);

  localparam logic [WIDTH-1:0] Y_RST   = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic y_change_c;
  logic cnt_sat_c;

  // Zero-latency NAND. X/Z resolve per standard ~& semantics.
  assign Y = ~(A & B);

  // Y_q is about to change value at this edge.
  assign y_change_c = (Y != Y_q);
  assign cnt_sat_c  = (toggles == CNT_MAX);

  // Registered copy of Y. Reset value is the NAND of 0,0.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y_q <= Y_RST;
    end else begin
      Y_q <= Y;
    end
  end

  // Transition counter. It saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      toggles <= '0;
    end else if (y_change_c && !cnt_sat_c) begin
      toggles <= toggles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_nand_gate.sv
// Directed, table-driven bench for nand_gate.
// It covers the truth table, reset behaviour, counter saturation and multi-bit independence.
module tb_nand_gate;

  logic clk;
  logic rst;

  // Tied-off instance: clk and rst held low, combinational path only.
  logic       t_a, t_b;
  logic       t_y, t_yq;
  logic [7:0] t_tog;

  // WIDTH=1, CNT_W=8
  logic       s_a, s_b;
  logic       s_y, s_yq;
  logic [7:0] s_tog;

  // WIDTH=1, CNT_W=2
  logic       c_a, c_b;
  logic       c_y, c_yq;
  logic [1:0] c_tog;

  // WIDTH=4, CNT_W=8
  logic [3:0] w_a, w_b;
  logic [3:0] w_y, w_yq;
  logic [7:0] w_tog;

  int n_cmp;
  int n_err;

  nand_gate #(.WIDTH(1), .CNT_W(8)) u_tie (
    .clk(1'b0), .rst(1'b0), .A(t_a), .B(t_b), .Y(t_y), .Y_q(t_yq), .toggles(t_tog)
  );

  nand_gate #(.WIDTH(1), .CNT_W(8)) u_w1 (
    .clk(clk), .rst(rst), .A(s_a), .B(s_b), .Y(s_y), .Y_q(s_yq), .toggles(s_tog)
  );

  nand_gate #(.WIDTH(1), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .A(c_a), .B(c_b), .Y(c_y), .Y_q(c_yq), .toggles(c_tog)
  );

  nand_gate #(.WIDTH(4), .CNT_W(8)) u_w4 (
    .clk(clk), .rst(rst), .A(w_a), .B(w_b), .Y(w_y), .Y_q(w_yq), .toggles(w_tog)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic a;
    logic b;
    logic y;
  } vec1_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
  } vec4_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec1_t tt[4];
    vec4_t tw[5];
    int    exp_tog;

    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    t_a = 1'b0; t_b = 1'b0;
    s_a = 1'b0; s_b = 1'b0;
    c_a = 1'b0; c_b = 1'b0;
    w_a = 4'h0; w_b = 4'h0;

    tt[0] = '{a: 1'b0, b: 1'b0, y: 1'b1};
    tt[1] = '{a: 1'b1, b: 1'b0, y: 1'b1};
    tt[2] = '{a: 1'b0, b: 1'b1, y: 1'b1};
    tt[3] = '{a: 1'b1, b: 1'b1, y: 1'b0};

    tw[0] = '{a: 4'b1100, b: 4'b1010, y: 4'b0111};
    tw[1] = '{a: 4'b0000, b: 4'b1111, y: 4'b1111};
    tw[2] = '{a: 4'b1111, b: 4'b1111, y: 4'b0000};
    tw[3] = '{a: 4'b0101, b: 4'b1111, y: 4'b1010};
    tw[4] = '{a: 4'b1001, b: 4'b0011, y: 4'b1110};

    // Truth table on the tied-off instance, 10 time units per step.
    for (int i = 0; i < 4; i++) begin
      t_a = tt[i].a;
      t_b = tt[i].b;
      #10;
      check($sformatf("tie_y[%0d]", i), 32'(t_y), 32'(tt[i].y));
    end

    // Reset for 2 edges while A=B=1. Y must still follow the inputs during reset.
    #1;
    rst = 1'b1;
    s_a = 1'b1; s_b = 1'b1;
    w_a = 4'b1100; w_b = 4'b1010;
    #1;
    check("y_during_rst", 32'(s_y), 32'h0);
    tick();
    tick();
    check("rst_yq", 32'(s_yq), 32'h1);
    check("rst_tog", 32'(s_tog), 32'h0);
    check("rst_c2_tog", 32'(c_tog), 32'h0);
    check("rst_w4_yq", 32'(w_yq), 32'hF);
    check("y_during_rst2", 32'(s_y), 32'h0);

    // A=B=1 held after reset. One toggle is expected, and then no more.
    rst = 1'b0;
    check("y_imm", 32'(s_y), 32'h0);
    tick();
    check("yq_after1", 32'(s_yq), 32'h0);
    check("tog_after1", 32'(s_tog), 32'h1);
    check("w4_y", 32'(w_y), 32'h7);
    check("w4_yq", 32'(w_yq), 32'h7);
    check("w4_tog", 32'(w_tog), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("tog_hold[%0d]", i), 32'(s_tog), 32'h1);
    end

    // WIDTH=4 vectors: Y immediately, then Y_q one edge later.
    for (int i = 0; i < 5; i++) begin
      w_a = tw[i].a;
      w_b = tw[i].b;
      #1;
      check($sformatf("w4_vec_y[%0d]", i), 32'(w_y), 32'(tw[i].y));
      tick();
      check($sformatf("w4_vec_yq[%0d]", i), 32'(w_yq), 32'(tw[i].y));
    end

    // CNT_W=2: alternate 11/00 every cycle. The counter saturates at 3.
    exp_tog = 0;
    for (int i = 0; i < 10; i++) begin
      c_a = (i % 2 == 0);
      c_b = (i % 2 == 0);
      tick();
      if (exp_tog < 3) exp_tog++;
      check($sformatf("c2_tog[%0d]", i), 32'(c_tog), 32'(exp_tog));
      check($sformatf("c2_yq[%0d]", i), 32'(c_yq), (i % 2 == 0) ? 32'h0 : 32'h1);
    end

    // Bring toggles to 2, then assert reset with A=B=1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_a = 1'b1; s_b = 1'b1;
    tick();
    s_a = 1'b0; s_b = 1'b0;
    tick();
    check("pre_rst_tog", 32'(s_tog), 32'h2);
    s_a = 1'b1; s_b = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_pending_tog", 32'(s_tog), 32'h2);
    tick();
    check("mid_rst_tog", 32'(s_tog), 32'h0);
    check("mid_rst_yq", 32'(s_yq), 32'h1);
    check("mid_rst_y", 32'(s_y), 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_tog", 32'(s_tog), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
